// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Serialises the fetch stage and the MEM stage onto one byte-addressed,
// single-ported memory. Data requests win, except that fetch is forced
// through after MAX_D_STREAK consecutive data grants while it is waiting.
// Accesses that see no mem_ready for TIMEOUT cycles are aborted with an error.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr           fetch request (always a word read)
//   if_done/if_err/if_rdata  fetch completion pulse, timeout flag, fetched word
//   d_req/d_we/d_size/d_signed/d_addr/d_wdata   data request and command
//   d_done/d_err/d_rdata     data completion pulse, error flag, load result
//   mem_req/mem_we/mem_size/mem_signed/mem_addr/mem_wdata   memory command
//   mem_rdata/mem_ready      memory response
//   busy                     an access is in flight
module unified_mem_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT      = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [7:0]  if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_signed,
  input  logic [7:0]  d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        if_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic        mem_signed,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy
);

  localparam int unsigned STREAK_W = 4;
  localparam int unsigned TMO_W    = 8;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  // Abort is taken on the last allowed cycle so mem_req spans exactly TIMEOUT cycles.
  localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT - 1);
  localparam logic [1:0]          SIZE_WORD  = 2'b00;
  localparam logic [1:0]          SIZE_BAD   = 2'b11;

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t              state;
  logic [STREAK_W-1:0] streak;
  logic [TMO_W-1:0]    tmo;
  logic                grant_d_c;
  logic                grant_f_c;
  logic                d_bad_c;

  // Arbitration decision; only acted on while IDLE.
  always_comb begin
    grant_d_c = 1'b0;
    grant_f_c = 1'b0;
    d_bad_c   = (d_size == SIZE_BAD);
    if (d_req && !(if_req && (streak == STREAK_MAX))) begin
      grant_d_c = 1'b1;
    end else if (if_req) begin
      grant_f_c = 1'b1;
    end
  end

  // Sequencer, streak tracking and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      streak     <= '0;
      tmo        <= '0;
      busy       <= 1'b0;
      if_done    <= 1'b0;
      if_err     <= 1'b0;
      if_rdata   <= '0;
      d_done     <= 1'b0;
      d_err      <= 1'b0;
      d_rdata    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_size   <= '0;
      mem_signed <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      if_done <= 1'b0;
      if_err  <= 1'b0;
      d_done  <= 1'b0;
      d_err   <= 1'b0;

      // Streak only counts data grants that fetch actually waited through.
      if (!if_req) begin
        streak <= '0;
      end else if (state == IDLE && grant_f_c) begin
        streak <= '0;
      end else if (state == IDLE && grant_d_c && !d_bad_c && streak != STREAK_MAX) begin
        streak <= streak + STREAK_W'(1);
      end

      case (state)
        IDLE: begin
          tmo <= '0;
          if (grant_d_c) begin
            if (d_bad_c) begin
              // Rejected without touching the memory port.
              d_done  <= 1'b1;
              d_err   <= 1'b1;
              d_rdata <= '0;
            end else begin
              state      <= DATA;
              busy       <= 1'b1;
              mem_req    <= 1'b1;
              mem_we     <= d_we;
              mem_size   <= d_size;
              mem_signed <= d_signed & ~d_we;
              mem_addr   <= d_addr;
              mem_wdata  <= d_wdata;
            end
          end else if (grant_f_c) begin
            state      <= FETCH;
            busy       <= 1'b1;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_size   <= SIZE_WORD;
            mem_signed <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
          end
        end

        FETCH, DATA: begin
          if (mem_ready) begin
            state   <= IDLE;
            busy    <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (state == FETCH) begin
              if_done  <= 1'b1;
              if_rdata <= mem_rdata;
            end else begin
              d_done  <= 1'b1;
              d_rdata <= mem_we ? '0 : mem_rdata;
            end
          end else if (tmo == TMO_LAST) begin
            state   <= IDLE;
            busy    <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (state == FETCH) begin
              if_done  <= 1'b1;
              if_err   <= 1'b1;
              if_rdata <= '0;
            end else begin
              d_done  <= 1'b1;
              d_err   <= 1'b1;
              d_rdata <= '0;
            end
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
        end

        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed and randomized bench for unified_mem_arbiter. The bench plays both
// requesters and the memory; expectations come from the arbitration and
// completion rules tracked transaction by transaction.
module tb_unified_mem_arbiter;

  localparam int MAXS = 4;
  localparam int TO   = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [7:0]  if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic        d_signed;
  logic [7:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic        d_err;
  logic [31:0] d_rdata;
  logic        if_err;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic        mem_signed;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  unified_mem_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_signed(d_signed),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done), .d_err(d_err),
    .d_rdata(d_rdata), .if_err(if_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_signed(mem_signed),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  bit          if_pend, d_pend, win_d, timed_out, seen;
  int          m_streak, lat, finish_k, hi;
  logic [31:0] rd, exp_if_rdata, exp_d_rdata;
  logic [7:0]  exp_addr;

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_size = '0; d_signed = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    step(); step();

    // Reset state
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_if_done", if_done, 0);
    chk("rst_d_done", d_done, 0);
    chk("rst_errs", {if_err, d_err}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_mem_cmd", {mem_we, mem_size, mem_signed, mem_addr}, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    step();

    // Single fetch, minimum latency
    if_req = 1'b1; if_addr = 8'h14;
    step();
    chk("fetch_mem_req", mem_req, 1);
    chk("fetch_mem_addr", mem_addr, 8'h14);
    chk("fetch_mem_we", mem_we, 0);
    chk("fetch_mem_size", mem_size, 0);
    chk("fetch_busy", busy, 1);
    mem_ready = 1'b1; mem_rdata = 32'h00402103;
    step();
    chk("fetch_done", if_done, 1);
    chk("fetch_rdata", if_rdata, 32'h00402103);
    chk("fetch_err", if_err, 0);
    chk("fetch_req_drop", mem_req, 0);
    chk("fetch_idle", busy, 0);
    if_req = 1'b0; mem_ready = 1'b0;
    step();
    chk("fetch_pulse_one", if_done, 0);
    chk("fetch_rdata_held", if_rdata, 32'h00402103);

    // Simultaneous requests: data first, fetch one cycle after d_done
    if_req = 1'b1; if_addr = 8'h20;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b00; d_addr = 8'h00;
    step();
    chk("sim_data_req", mem_req, 1);
    chk("sim_data_addr", mem_addr, 8'h00);
    mem_ready = 1'b1; mem_rdata = 32'd17;
    step();
    chk("sim_d_done", d_done, 1);
    chk("sim_d_rdata", d_rdata, 32'd17);
    chk("sim_no_if_done", if_done, 0);
    chk("sim_gap", mem_req, 0);
    d_req = 1'b0; mem_rdata = 32'hCAFE0001;
    step();
    chk("sim_fetch_req", mem_req, 1);
    chk("sim_fetch_addr", mem_addr, 8'h20);
    step();
    chk("sim_if_done", if_done, 1);
    chk("sim_if_rdata", if_rdata, 32'hCAFE0001);
    if_req = 1'b0; mem_ready = 1'b0;
    step();

    // Streak limit: D,D,D,D,F,D,D,D,D,F
    if_req = 1'b1; if_addr = 8'h80;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b00; d_addr = 8'h40;
    mem_ready = 1'b1; mem_rdata = 32'h55;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("streak_req%0d", i), mem_req, 1);
      chk($sformatf("streak_grant%0d", i), mem_addr, (i % 5 == 4) ? 8'h80 : 8'h40);
      step();
      chk($sformatf("streak_done%0d", i), {if_done, d_done}, (i % 5 == 4) ? 2'b10 : 2'b01);
    end
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    step();

    // Illegal size: rejected without a memory access
    d_req = 1'b1; d_size = 2'b11; d_we = 1'b0; d_addr = 8'h44;
    step();
    chk("bad_no_req", mem_req, 0);
    chk("bad_done", d_done, 1);
    chk("bad_err", d_err, 1);
    chk("bad_rdata", d_rdata, 0);
    chk("bad_busy", busy, 0);
    d_req = 1'b0; d_size = 2'b00;
    step();
    chk("bad_pulse_one", {d_done, d_err}, 0);
    chk("bad_still_no_req", mem_req, 0);

    // Byte store
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_wdata = 32'h000001AB; d_addr = 8'h33;
    step();
    chk("st_req", mem_req, 1);
    chk("st_we", mem_we, 1);
    chk("st_size", mem_size, 2'b10);
    chk("st_wdata", mem_wdata, 32'h000001AB);
    chk("st_addr", mem_addr, 8'h33);
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();
    chk("st_done", d_done, 1);
    chk("st_err", d_err, 0);
    chk("st_rdata_zero", d_rdata, 0);
    d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; mem_ready = 1'b0;
    step();

    // Fetch timeout
    if_req = 1'b1; if_addr = 8'h10; mem_rdata = 32'h12345678;
    hi = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (mem_req) hi++;
      if (if_done) seen = 1'b1;
    end
    chk("tmo_seen", seen, 1);
    chk("tmo_req_cycles", hi, TO);
    chk("tmo_if_err", if_err, 1);
    chk("tmo_if_rdata", if_rdata, 0);
    chk("tmo_req_low", mem_req, 0);
    if_req = 1'b0;
    step();
    chk("tmo_err_pulse_one", if_err, 0);

    // Reset in the middle of an access
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b00; d_addr = 8'h08;
    step();
    chk("rmid_req_before", mem_req, 1);
    step(); step();
    rst = 1'b1; d_req = 1'b0;
    step();
    chk("rmid_req", mem_req, 0);
    chk("rmid_busy", busy, 0);
    chk("rmid_no_done", d_done, 0);
    rst = 1'b0;
    step();
    chk("rmid_no_done_after", d_done, 0);
    chk("rmid_idle", mem_req, 0);

    // Randomized traffic against the transaction model
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_streak = 0; exp_if_rdata = '0; exp_d_rdata = '0;
    if_pend = 1'b0; d_pend = 1'b0;
    for (int t = 0; t < 300; t++) begin
      if (!if_pend && $urandom_range(0, 99) < 60) begin
        if_pend = 1'b1;
        if_addr = 8'($urandom);
      end
      if (!d_pend && $urandom_range(0, 99) < 70) begin
        d_pend   = 1'b1;
        d_we     = 1'($urandom);
        d_size   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        d_signed = 1'($urandom);
        d_addr   = 8'($urandom);
        d_wdata  = $urandom;
      end
      if_req = if_pend;
      d_req  = d_pend;
      if (!if_pend && !d_pend) begin
        m_streak = 0;
        step();
        chk("rnd_idle", mem_req, 0);
        continue;
      end

      win_d = d_pend && !(if_pend && m_streak == MAXS);
      if (!if_pend || !win_d) m_streak = 0;
      else if (d_size != 2'b11) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;

      step();
      if (win_d && d_size == 2'b11) begin
        chk("rnd_bad_no_req", mem_req, 0);
        chk("rnd_bad_done", {if_done, d_done, d_err}, 3'b011);
        chk("rnd_bad_rdata", d_rdata, 0);
        exp_d_rdata = '0;
        d_pend = 1'b0;
        continue;
      end

      exp_addr = win_d ? d_addr : if_addr;
      chk("rnd_grant_req", mem_req, 1);
      chk("rnd_grant_busy", busy, 1);
      chk("rnd_grant_addr", mem_addr, exp_addr);
      chk("rnd_grant_we", mem_we, win_d ? d_we : 1'b0);
      chk("rnd_grant_size", mem_size, win_d ? d_size : 2'b00);
      if (win_d && !d_we) chk("rnd_grant_signed", mem_signed, d_signed);
      if (win_d && d_we)  chk("rnd_grant_wdata", mem_wdata, d_wdata);

      lat       = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 3));
      timed_out = (lat + 1 > TO);
      finish_k  = timed_out ? TO : lat + 1;
      rd        = '0;
      for (int k = 1; k <= finish_k; k++) begin
        mem_ready = (k == lat + 1);
        mem_rdata = $urandom;
        rd        = mem_rdata;
        step();
        if (k < finish_k) begin
          chk("rnd_hold_req", mem_req, 1);
          chk("rnd_hold_addr", mem_addr, exp_addr);
          chk("rnd_hold_no_done", {if_done, d_done}, 0);
        end
      end
      mem_ready = 1'b0;

      if (win_d) begin
        exp_d_rdata = (timed_out || d_we) ? 32'h0 : rd;
        chk("rnd_d_done", {if_done, d_done}, 2'b01);
        chk("rnd_d_err", d_err, timed_out);
        chk("rnd_d_rdata", d_rdata, exp_d_rdata);
        chk("rnd_if_rdata_held", if_rdata, exp_if_rdata);
        d_pend = 1'b0;
      end else begin
        exp_if_rdata = timed_out ? 32'h0 : rd;
        chk("rnd_if_done", {if_done, d_done}, 2'b10);
        chk("rnd_if_err", if_err, timed_out);
        chk("rnd_if_rdata", if_rdata, exp_if_rdata);
        chk("rnd_d_rdata_held", d_rdata, exp_d_rdata);
        if_pend = 1'b0;
      end
      chk("rnd_done_req_low", mem_req, 0);
      chk("rnd_done_idle", busy, 0);
    end
    if_req = 1'b0; d_req = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
